// File: rtl/signal_trig_pkg.sv
// Shared definitions for the level-crossing trigger detector: state encoding
// and slope select constants.
package signal_trig_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_SEEK    = 2'd1;
   localparam logic [1:0] ST_ARMED   = 2'd2;
   localparam logic [1:0] ST_HOLDOFF = 2'd3;

   localparam logic SLOPE_RISE = 1'b0;
   localparam logic SLOPE_FALL = 1'b1;

   typedef enum logic [1:0] {
      TS_IDLE    = ST_IDLE,
      TS_SEEK    = ST_SEEK,
      TS_ARMED   = ST_ARMED,
      TS_HOLDOFF = ST_HOLDOFF
   } trig_state_e;

endpackage

// File: rtl/signal_trig_if.sv
// Sample stream feeding the trigger detector: a qualifier plus an unsigned sample.
interface signal_trig_if #(
   parameter int DATA_W = 12
);
   logic              sample_valid;
   logic [DATA_W-1:0] sample_data;

   modport master (output sample_valid, output sample_data);
   modport slave  (input  sample_valid, input  sample_data);
endinterface

// File: rtl/signal_trig_holdoff.sv
// Post-trigger dead-time counter: loads on a fire, counts down to zero, then
// sits at zero and flags it.
module signal_trig_holdoff #(
   parameter int HOLDOFF_W = 24
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 dec,
   input  logic [HOLDOFF_W-1:0] load_val,
   output logic                 zero
);

   logic [HOLDOFF_W-1:0] hcnt_r;

   // Load takes priority over decrement; the count never wraps below zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hcnt_r <= '0;
      end else if (load) begin
         hcnt_r <= load_val;
      end else if (dec && (hcnt_r != '0)) begin
         hcnt_r <= hcnt_r - HOLDOFF_W'(1);
      end else begin
         hcnt_r <= hcnt_r;
      end
   end

   assign zero = (hcnt_r == '0);

endmodule

// File: rtl/signal_trig_detect.sv
// Level-crossing trigger detector: threshold with hysteresis and slope select,
// one-clock trigger pulse, programmable holdoff and a saturating event counter.
module signal_trig_detect
   import signal_trig_pkg::*;
#(
   parameter int DATA_W    = 12,
   parameter int HOLDOFF_W = 24,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 trig_en,
   input  logic                 trig_slope,
   input  logic [DATA_W-1:0]    trig_level,
   input  logic [DATA_W-1:0]    trig_hyst,
   input  logic [HOLDOFF_W-1:0] holdoff,
   signal_trig_if.slave         smp,
   output logic                 trig_sig_out,
   output logic                 trig_armed,
   output logic [1:0]           trig_state,
   output logic [CNT_W-1:0]     trig_cnt
);

   trig_state_e          state_r, next_s;
   logic                 slope_r;
   logic [DATA_W-1:0]    level_r, hyst_r;
   logic [HOLDOFF_W-1:0] hold_cfg_r;
   logic                 pulse_r, armed_r;
   logic [CNT_W-1:0]     cnt_r;
   logic [DATA_W:0]      diff_s, sum_s;
   logic [DATA_W-1:0]    lo_s, hi_s;
   logic                 pre_s, fire_cond_s;
   logic                 latch_s, fire_s, dec_s, h_zero_s;

   // Band edges in one extra bit so underflow/overflow show up in the top bit.
   always_comb begin
      diff_s = {1'b0, level_r} - {1'b0, hyst_r};
      sum_s  = {1'b0, level_r} + {1'b0, hyst_r};
      if (diff_s[DATA_W]) begin
         lo_s = '0;
      end else begin
         lo_s = diff_s[DATA_W-1:0];
      end
      if (sum_s[DATA_W]) begin
         hi_s = '1;
      end else begin
         hi_s = sum_s[DATA_W-1:0];
      end
   end

   // Pre-condition leaves the far side of the band; fire condition crosses the level.
   always_comb begin
      if (slope_r == SLOPE_RISE) begin
         pre_s       = (smp.sample_data <  lo_s);
         fire_cond_s = (smp.sample_data >= level_r);
      end else begin
         pre_s       = (smp.sample_data >  hi_s);
         fire_cond_s = (smp.sample_data <= level_r);
      end
   end

   // Next-state logic; a disable overrides everything, including a same-cycle fire.
   always_comb begin
      next_s  = state_r;
      latch_s = 1'b0;
      fire_s  = 1'b0;
      dec_s   = 1'b0;
      if (!trig_en) begin
         next_s = TS_IDLE;
      end else begin
         case (state_r)
            TS_IDLE: begin
               next_s  = TS_SEEK;
               latch_s = 1'b1;
            end
            TS_SEEK: begin
               if (smp.sample_valid && pre_s) next_s = TS_ARMED;
               else                           next_s = TS_SEEK;
            end
            TS_ARMED: begin
               if (smp.sample_valid && fire_cond_s) begin
                  next_s = TS_HOLDOFF;
                  fire_s = 1'b1;
               end else begin
                  next_s = TS_ARMED;
               end
            end
            TS_HOLDOFF: begin
               if (h_zero_s) next_s = TS_SEEK;
               else          dec_s  = 1'b1;
            end
            default: next_s = TS_IDLE;
         endcase
      end
   end

   signal_trig_holdoff #(.HOLDOFF_W(HOLDOFF_W)) u_holdoff (
      .clk      (clk),
      .rst      (rst),
      .load     (fire_s),
      .dec      (dec_s),
      .load_val (hold_cfg_r),
      .zero     (h_zero_s)
   );

   // State, latched configuration and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= TS_IDLE;
         slope_r    <= 1'b0;
         level_r    <= '0;
         hyst_r     <= '0;
         hold_cfg_r <= '0;
         pulse_r    <= 1'b0;
         armed_r    <= 1'b0;
         cnt_r      <= '0;
      end else begin
         state_r <= next_s;
         pulse_r <= fire_s;
         armed_r <= (next_s == TS_ARMED);
         if (latch_s) begin
            slope_r    <= trig_slope;
            level_r    <= trig_level;
            hyst_r     <= trig_hyst;
            hold_cfg_r <= holdoff;
         end
         if (fire_s && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + CNT_W'(1);
         end
      end
   end

   assign trig_sig_out = pulse_r;
   assign trig_armed   = armed_r;
   assign trig_state   = state_r;
   assign trig_cnt     = cnt_r;

endmodule

// File: tb/tb_signal_trig_detect.sv
// Scoreboard bench for signal_trig_detect: a reference model pushes expected
// outputs per driven cycle; they are popped and compared after the clock edge.
`timescale 1ns/1ps
module tb_signal_trig_detect;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        trig_en = 1'b0;
   logic        trig_slope = 1'b0;
   logic [11:0] trig_level = 12'd2048;
   logic [11:0] trig_hyst = 12'd64;
   logic [23:0] holdoff = 24'd10;
   logic        trig_sig_out, trig_armed;
   logic [1:0]  trig_state;
   logic [15:0] trig_cnt;

   always #5 clk = ~clk;

   signal_trig_if #(.DATA_W(12)) smp_if ();

   signal_trig_detect #(.DATA_W(12), .HOLDOFF_W(24), .CNT_W(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .trig_en      (trig_en),
      .trig_slope   (trig_slope),
      .trig_level   (trig_level),
      .trig_hyst    (trig_hyst),
      .holdoff      (holdoff),
      .smp          (smp_if),
      .trig_sig_out (trig_sig_out),
      .trig_armed   (trig_armed),
      .trig_state   (trig_state),
      .trig_cnt     (trig_cnt)
   );

   typedef struct packed {
      logic        pulse;
      logic [1:0]  state;
      logic        armed;
      logic [15:0] cnt;
   } exp_t;

   exp_t sb_q[$];
   int   pulse_q[$];
   int   errors = 0;
   int   checks = 0;
   int   m_state = 0, m_cnt = 0, m_hcnt = 0;
   int   m_slope = 0, m_level = 0, m_hyst = 0, m_hold = 0;
   int   cyc = 0, n_pulse = 0, n_hold = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_stats();
      cyc = 0;
      n_pulse = 0;
      n_hold = 0;
      pulse_q.delete();
   endtask

   task automatic step(input logic en, input logic v, input int d);
      exp_t e;
      int   nxt, lo, hi;
      bit   fire;
      trig_en = en;
      smp_if.sample_valid = v;
      smp_if.sample_data = d[11:0];
      lo = m_level - m_hyst;
      if (lo < 0) lo = 0;
      hi = m_level + m_hyst;
      if (hi > 4095) hi = 4095;
      nxt = m_state;
      fire = 1'b0;
      if (!en) begin
         nxt = 0;
      end else begin
         case (m_state)
            0: begin
               nxt = 1;
               m_slope = int'(trig_slope);
               m_level = int'(trig_level);
               m_hyst = int'(trig_hyst);
               m_hold = int'(holdoff);
            end
            1: if (v && ((m_slope != 0) ? (d > hi) : (d < lo))) nxt = 2;
            2: if (v && ((m_slope != 0) ? (d <= m_level) : (d >= m_level))) begin
               nxt = 3;
               fire = 1'b1;
               m_hcnt = m_hold;
            end
            3: if (m_hcnt == 0) nxt = 1; else m_hcnt--;
            default: nxt = 0;
         endcase
      end
      if (fire && m_cnt < 65535) m_cnt++;
      m_state = nxt;
      e.pulse = fire;
      e.state = nxt[1:0];
      e.armed = (nxt == 2);
      e.cnt = m_cnt[15:0];
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check_val("pulse", {31'd0, trig_sig_out}, {31'd0, e.pulse});
      check_val("state", {30'd0, trig_state}, {30'd0, e.state});
      check_val("armed", {31'd0, trig_armed}, {31'd0, e.armed});
      check_val("cnt", {16'd0, trig_cnt}, {16'd0, e.cnt});
      cyc++;
      if (trig_sig_out) begin
         n_pulse++;
         pulse_q.push_back(cyc);
      end
      if (trig_state == 2'd3) n_hold++;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      sb_q.delete();
      m_state = 0; m_cnt = 0; m_hcnt = 0;
      m_slope = 0; m_level = 0; m_hyst = 0; m_hold = 0;
      check_val("rst_pulse", {31'd0, trig_sig_out}, 32'd0);
      check_val("rst_state", {30'd0, trig_state}, 32'd0);
      check_val("rst_armed", {31'd0, trig_armed}, 32'd0);
      check_val("rst_cnt", {16'd0, trig_cnt}, 32'd0);
   endtask

   initial begin
      int s;
      smp_if.sample_valid = 1'b0;
      smp_if.sample_data = 12'd0;
      #2;
      do_reset();
      @(negedge clk);
      rst = 1'b1;

      // 1: rising ramp through the level
      clear_stats();
      step(1'b1, 1'b0, 0);
      for (int k = 0; k < 256; k++) step(1'b1, 1'b1, k * 16);
      check_val("t1_pulses", n_pulse, 32'd1);
      check_val("t1_cnt", {16'd0, trig_cnt}, 32'd1);
      check_val("t1_hold_clks", n_hold, 32'd11);
      check_val("t1_latency", (pulse_q.size() > 0) ? pulse_q[0] : -1, 32'd130);

      // 2: falling ramp, then in-band noise
      step(1'b0, 1'b0, 0);
      trig_slope = 1'b1;
      clear_stats();
      step(1'b1, 1'b0, 0);
      for (int k = 0; k < 131; k++) step(1'b1, 1'b1, 4095 - 16 * k);
      for (int k = 0; k < 40; k++) step(1'b1, 1'b1, (k % 2 == 0) ? 2040 : 2060);
      check_val("t2_pulses", n_pulse, 32'd1);
      check_val("t2_cnt", {16'd0, trig_cnt}, 32'd2);

      // 3: sine, zero holdoff
      step(1'b0, 1'b0, 0);
      trig_slope = 1'b0;
      holdoff = 24'd0;
      clear_stats();
      step(1'b1, 1'b0, 0);
      for (int k = 0; k < 500; k++) begin
         s = $rtoi(2048.0 + 1800.0 * $sin(2.0 * 3.14159265358979 * (real'(k) + 0.25) / 100.0));
         step(1'b1, 1'b1, s);
      end
      check_val("t3_pulses", n_pulse, 32'd4);
      for (int i = 0; i < 3; i++) begin
         if (i + 1 < pulse_q.size()) check_val("t3_spacing", pulse_q[i+1] - pulse_q[i], 32'd100);
         else check_val("t3_spacing", 32'd0, 32'd100);
      end

      // 4: disable on the firing cycle
      step(1'b0, 1'b0, 0);
      holdoff = 24'd10;
      clear_stats();
      step(1'b1, 1'b0, 0);
      step(1'b1, 1'b1, 1000);
      step(1'b0, 1'b1, 2100);
      check_val("t4_pulses", n_pulse, 32'd0);
      check_val("t4_cnt", {16'd0, trig_cnt}, 32'd6);
      check_val("t4_idle", {30'd0, trig_state}, 32'd0);

      // 5: level change while armed is ignored until relatched
      clear_stats();
      step(1'b1, 1'b0, 0);
      step(1'b1, 1'b1, 1000);
      trig_level = 12'd100;
      step(1'b1, 1'b1, 500);
      step(1'b1, 1'b1, 2100);
      check_val("t5_old_level", n_pulse, 32'd1);
      for (int k = 0; k < 12; k++) step(1'b1, 1'b0, 0);
      step(1'b0, 1'b0, 0);
      step(1'b1, 1'b0, 0);
      step(1'b1, 1'b1, 10);
      step(1'b1, 1'b1, 150);
      check_val("t5_new_level", n_pulse, 32'd2);
      check_val("t5_cnt", {16'd0, trig_cnt}, 32'd8);

      // 6: reset in the middle of holdoff
      step(1'b0, 1'b0, 0);
      trig_level = 12'd2048;
      step(1'b1, 1'b0, 0);
      step(1'b1, 1'b1, 1000);
      step(1'b1, 1'b1, 2100);
      for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 0);
      check_val("t6_in_holdoff", {30'd0, trig_state}, 32'd3);
      do_reset();
      @(negedge clk);
      rst = 1'b1;
      step(1'b1, 1'b0, 0);
      check_val("t6_seek", {30'd0, trig_state}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
